// File: rtl/kgp_fetch_branch_unit.sv
// Multi-cycle fetch / next-PC unit for KGP-RISC.
// Sequences fetch over a ready-handshake instruction memory, holds the
// fetched instruction for execute, resolves the next PC from the condition
// code, keeps the Z/C/S/V flag register and a circular return-address stack.
module kgp_fetch_branch_unit #(
    parameter int AW        = 32,
    parameter int IW        = 32,
    parameter int RAS_DEPTH = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [AW-1:0] TRAP_PC  = AW'('h10)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic [AW-1:0] link_addr,
    input  logic          exec_valid,
    input  logic [3:0]    exec_cond,
    input  logic [AW-1:0] exec_offset,
    input  logic [AW-1:0] exec_target,
    input  logic          flag_we,
    input  logic [3:0]    flags_in,
    output logic [3:0]    flags,
    output logic          halted,
    output logic          ras_ovf,
    output logic          ras_unf
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   pc, pc_nx;
    logic [AW-1:0]   seq, tgt;
    logic [AW-1:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0]   sp;          // next free slot; top of stack is sp-1
    logic [PW-1:0]   sp_top;
    logic [CW-1:0]   count;
    logic            do_push, do_pop;
    logic            issue, ras_full, ras_empty;
    logic            fz, fc, fs, fv;

    assign seq       = instr_pc + AW'(1);
    assign tgt       = seq + exec_offset;
    assign link_addr = seq;
    assign imem_addr = pc;
    assign sp_top    = sp - PW'(1);
    assign ras_full  = (count == CW'(RAS_DEPTH));
    assign ras_empty = (count == '0);
    assign issue     = (state == ISSUE) && exec_valid;
    assign {fv, fs, fc, fz} = flags;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE:  state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_nx = ISSUE;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (exec_valid) state_nx = (exec_cond == 4'd15) ? HALT : FETCH;
            end
            HALT:  halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    // Next-PC select; conditions see the flags before this instruction's update
    always_comb begin
        pc_nx   = seq;
        do_push = 1'b0;
        do_pop  = 1'b0;
        case (exec_cond)
            4'd1:  pc_nx = tgt;
            4'd2:  pc_nx = exec_target;
            4'd3:  pc_nx = fz  ? tgt : seq;
            4'd4:  pc_nx = !fz ? tgt : seq;
            4'd5:  pc_nx = fc  ? tgt : seq;
            4'd6:  pc_nx = !fc ? tgt : seq;
            4'd7:  pc_nx = fs  ? tgt : seq;
            4'd8:  pc_nx = !fs ? tgt : seq;
            4'd9:  pc_nx = fv  ? tgt : seq;
            4'd10: pc_nx = !fv ? tgt : seq;
            4'd11: begin
                do_push = 1'b1;
                pc_nx   = tgt;
            end
            4'd12: begin
                do_pop = 1'b1;
                pc_nx  = ras_empty ? TRAP_PC : ras_mem[sp_top];
            end
            4'd15: pc_nx = pc;
            default: pc_nx = seq;
        endcase
    end

    // PC, fetched instruction, flags and RAS bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
            flags    <= '0;
            sp       <= '0;
            count    <= '0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
        end else begin
            if (state == FETCH && imem_ready) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (issue) begin
                pc <= pc_nx;
                if (flag_we) flags <= flags_in;
                if (do_push) begin
                    // when full the write lands on the oldest slot
                    sp <= sp + PW'(1);
                    if (ras_full) ras_ovf <= 1'b1;
                    else          count   <= count + CW'(1);
                end
                if (do_pop) begin
                    if (ras_empty) begin
                        ras_unf <= 1'b1;
                    end else begin
                        sp    <= sp_top;
                        count <= count - CW'(1);
                    end
                end
            end
        end
    end

    // RAS storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (!reset && issue && do_push) ras_mem[sp] <= seq;
    end
endmodule
